// File: rtl/dbg_pkg.sv
// Shared definitions for the 68k debug run-control block: command codes,
// Avalon register offsets, scheduler state encoding and read defaults.
package dbg_pkg;

   localparam int unsigned AV_ADDR_W = 20;
   localparam int unsigned AV_DATA_W = 32;
   localparam int unsigned CMD_W     = 8;

   // Command opcodes carried in CTRL write data [31:24]
   localparam logic [CMD_W-1:0] CMD_HALT      = 8'h00;
   localparam logic [CMD_W-1:0] CMD_RUN       = 8'h01;
   localparam logic [CMD_W-1:0] CMD_STEP      = 8'h02;
   localparam logic [CMD_W-1:0] CMD_RUN_TO_BP = 8'h03;

   // Word-aligned byte offsets of the register map
   localparam logic [AV_ADDR_W-1:0] REG_CTRL      = 20'h00;
   localparam logic [AV_ADDR_W-1:0] REG_BP        = 20'h04;
   localparam logic [AV_ADDR_W-1:0] REG_STEP_REM  = 20'h08;
   localparam logic [AV_ADDR_W-1:0] REG_CYCLE_CNT = 20'h0C;
   localparam logic [AV_ADDR_W-1:0] REG_LAST_ADDR = 20'h10;

   localparam logic [AV_DATA_W-1:0] RD_UNMAPPED = 32'hDEAD_BEEF;

   typedef enum logic [2:0] {
      ST_RUNNING   = 3'd0,
      ST_HALT_PEND = 3'd1,
      ST_HALTED    = 3'd2,
      ST_STEPPING  = 3'd3,
      ST_BP_RUN    = 3'd4
   } state_e;

endpackage

// File: rtl/dbg_bus_cycle_mon.sv
// 68k bus-cycle monitor: detects AS_n edges, latches the address of each
// cycle and counts completed cycles.
//  i_clk_sys, i_reset : clock, async active-high reset
//  i_cpu_as_n         : 68k address strobe (active low)
//  i_cpu_addr         : 68k address bus
//  i_cnt_clr          : clear cycle counter (wins over a coincident cycle end)
//  o_cyc_start_c      : AS_n falling edge seen this clock (combinational)
//  o_cyc_end_c        : AS_n rising edge seen this clock (combinational)
//  o_last_addr        : address latched at the most recent cycle start
//  o_cycle_cnt        : number of completed bus cycles, wraps at 2^32
module dbg_bus_cycle_mon #(
   parameter int unsigned ADDR_W = 24
) (
   input  logic              i_clk_sys,
   input  logic              i_reset,
   input  logic              i_cpu_as_n,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic              i_cnt_clr,
   output logic              o_cyc_start_c,
   output logic              o_cyc_end_c,
   output logic [ADDR_W-1:0] o_last_addr,
   output logic [31:0]       o_cycle_cnt
);

   logic              r_as_q;
   logic [ADDR_W-1:0] r_last_addr;
   logic [31:0]       r_cycle_cnt;

   // Strobe history resets to the idle (high) level so reset release never
   // fakes an edge.
   always_ff @(posedge i_clk_sys or posedge i_reset) begin
      if (i_reset) r_as_q <= 1'b1;
      else         r_as_q <= i_cpu_as_n;
   end

   assign o_cyc_start_c = r_as_q & ~i_cpu_as_n;
   assign o_cyc_end_c   = ~r_as_q & i_cpu_as_n;

   // Address capture and completed-cycle counter
   always_ff @(posedge i_clk_sys or posedge i_reset) begin
      if (i_reset) begin
         r_last_addr <= '0;
         r_cycle_cnt <= '0;
      end else begin
         if (o_cyc_start_c) r_last_addr <= i_cpu_addr;
         if (i_cnt_clr)        r_cycle_cnt <= '0;
         else if (o_cyc_end_c) r_cycle_cnt <= r_cycle_cnt + 32'd1;
      end
   end

   assign o_last_addr = r_last_addr;
   assign o_cycle_cnt = r_cycle_cnt;

endmodule

// File: rtl/dbg_run_ctrl.sv
// Run-control scheduler for the 68k debug path. Owns cpu_clken and sequences
// HALT / RUN / STEP-N / RUN-TO-BREAKPOINT, always stopping on a bus-cycle end.
//  clk_sys, reset      : core clock, async active-high reset
//  av_*                : Avalon-MM slave from the HPS debug bridge (av_clk = clk_sys)
//  cpu_as_n, cpu_addr  : 68k bus monitor inputs
//  cpu_clken           : CPU clock enable (low only while HALTED)
//  halted              : 1 while the scheduler is HALTED
module dbg_run_ctrl
   import dbg_pkg::*;
#(
   parameter int unsigned ADDR_W       = 24,
   parameter int unsigned STEP_W       = 16,
   parameter bit          RESET_HALTED = 1'b0
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic [19:0]       av_address,
   input  logic              av_read,
   input  logic              av_write,
   input  logic [31:0]       av_writedata,
   input  logic [6:0]        av_burstcount,
   output logic [31:0]       av_readdata,
   output logic              av_readdatavalid,
   output logic              av_waitrequest,
   output logic              av_clk,
   input  logic              cpu_as_n,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic              cpu_clken,
   output logic              halted
);

   state_e              r_state, w_state_nxt;
   logic [STEP_W-1:0]   r_step_rem, w_step_rem_nxt;
   logic                r_bp_hit, w_bp_hit_nxt;
   logic                r_bp_en;
   logic [ADDR_W-1:0]   r_bp_addr;
   logic                r_clken, r_halted;
   logic                r_waitrequest, r_rdv;
   logic [31:0]         r_readdata;

   logic [19:0]         w_addr;
   logic                w_wr_accept, w_rd_accept;
   logic [CMD_W-1:0]    w_cmd;
   logic                w_cmd_valid;
   logic [STEP_W-1:0]   w_step_load;
   logic                w_cyc_start, w_cyc_end;
   logic [ADDR_W-1:0]   w_last_addr;
   logic [31:0]         w_cycle_cnt;
   logic [31:0]         w_rd_mux;
   logic                w_unused;

   assign av_clk   = clk_sys;
   assign w_unused = &{1'b0, av_burstcount, av_address[1:0], av_writedata};

   // Address decode and transfer acceptance; nothing is taken while stalled
   assign w_addr      = {av_address[19:2], 2'b00};
   assign w_wr_accept = av_write & ~r_waitrequest;
   assign w_rd_accept = av_read & ~r_waitrequest;
   assign w_cmd       = av_writedata[31:24];
   assign w_cmd_valid = w_wr_accept && (w_addr == REG_CTRL) && (w_cmd <= CMD_RUN_TO_BP);
   assign w_step_load = (av_writedata[STEP_W-1:0] == '0) ? STEP_W'(1)
                                                          : av_writedata[STEP_W-1:0];

   dbg_bus_cycle_mon #(.ADDR_W(ADDR_W)) u_mon (
      .i_clk_sys     (clk_sys),
      .i_reset       (reset),
      .i_cpu_as_n    (cpu_as_n),
      .i_cpu_addr    (cpu_addr),
      .i_cnt_clr     (w_wr_accept && (w_addr == REG_CYCLE_CNT)),
      .o_cyc_start_c (w_cyc_start),
      .o_cyc_end_c   (w_cyc_end),
      .o_last_addr   (w_last_addr),
      .o_cycle_cnt   (w_cycle_cnt)
   );

   // Scheduler state register plus the registered clock-enable/halted outputs
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_state    <= RESET_HALTED ? ST_HALTED : ST_RUNNING;
         r_step_rem <= '0;
         r_bp_hit   <= 1'b0;
         r_clken    <= ~RESET_HALTED;
         r_halted   <= RESET_HALTED;
      end else begin
         r_state    <= w_state_nxt;
         r_step_rem <= w_step_rem_nxt;
         r_bp_hit   <= w_bp_hit_nxt;
         r_clken    <= (w_state_nxt != ST_HALTED);
         r_halted   <= (w_state_nxt == ST_HALTED);
      end
   end

   // Next state: a new command overrides everything, including a coincident cycle end
   always_comb begin
      w_state_nxt    = r_state;
      w_step_rem_nxt = r_step_rem;
      w_bp_hit_nxt   = r_bp_hit;
      if (w_cmd_valid) begin
         w_bp_hit_nxt   = 1'b0;
         w_step_rem_nxt = '0;
         case (w_cmd)
            CMD_HALT:      if (r_state != ST_HALTED) w_state_nxt = ST_HALT_PEND;
            CMD_RUN:       w_state_nxt = ST_RUNNING;
            CMD_STEP: begin
               w_state_nxt    = ST_STEPPING;
               w_step_rem_nxt = w_step_load;
            end
            CMD_RUN_TO_BP: w_state_nxt = ST_BP_RUN;
            default:       w_state_nxt = r_state;
         endcase
      end else begin
         case (r_state)
            ST_HALT_PEND: if (w_cyc_end) w_state_nxt = ST_HALTED;
            ST_STEPPING: begin
               if (w_cyc_end) begin
                  if (r_step_rem <= STEP_W'(1)) begin
                     w_state_nxt    = ST_HALTED;
                     w_step_rem_nxt = '0;
                  end else begin
                     w_step_rem_nxt = r_step_rem - STEP_W'(1);
                  end
               end
            end
            // Match at cycle start; the halt then lands at the end of that same cycle
            ST_BP_RUN: begin
               if (w_cyc_start && r_bp_en && (cpu_addr == r_bp_addr)) begin
                  w_bp_hit_nxt = 1'b1;
                  w_state_nxt  = ST_HALT_PEND;
               end
            end
            default: w_state_nxt = r_state;
         endcase
      end
   end

   // Breakpoint register
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_bp_en   <= 1'b0;
         r_bp_addr <= '0;
      end else if (w_wr_accept && (w_addr == REG_BP)) begin
         r_bp_en   <= av_writedata[31];
         r_bp_addr <= av_writedata[ADDR_W-1:0];
      end
   end

   // Read mux
   always_comb begin
      w_rd_mux = RD_UNMAPPED;
      case (w_addr)
         REG_CTRL:      w_rd_mux = {23'd0, r_bp_hit, 5'd0, r_state};
         REG_BP:        w_rd_mux = {r_bp_en, 31'd0} | 32'(r_bp_addr);
         REG_STEP_REM:  w_rd_mux = 32'(r_step_rem);
         REG_CYCLE_CNT: w_rd_mux = w_cycle_cnt;
         REG_LAST_ADDR: w_rd_mux = 32'(w_last_addr);
         default:       w_rd_mux = RD_UNMAPPED;
      endcase
   end

   // Fixed one-cycle read response; waitrequest covers only the response cycle
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_waitrequest <= 1'b0;
         r_rdv         <= 1'b0;
         r_readdata    <= '0;
      end else begin
         r_waitrequest <= w_rd_accept;
         r_rdv         <= w_rd_accept;
         if (w_rd_accept) r_readdata <= w_rd_mux;
      end
   end

   assign av_readdata      = r_readdata;
   assign av_readdatavalid = r_rdv;
   assign av_waitrequest   = r_waitrequest;
   assign cpu_clken        = r_clken;
   assign halted           = r_halted;

endmodule
